// File: rtl/gpu_core_param_if.sv
// Bus bundle between the shader core, its task scheduler and shared memory.
// The core side uses the master modport; the scheduler/memory side uses slave.
interface gpu_core_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 12
);
    logic              val_ins;
    logic [15:0]       instruction;
    logic              rtr;
    logic              ready;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] addr_shared_memory;
    logic [DATA_W-1:0] mem_dat_st;
    logic [DATA_W-1:0] mem_dat;
    logic              val_data;

    modport master (
        input  val_ins, instruction, mem_dat, val_data,
        output rtr, ready, mem_req, mem_we, addr_shared_memory, mem_dat_st
    );

    modport slave (
        output val_ins, instruction, mem_dat, val_data,
        input  rtr, ready, mem_req, mem_we, addr_shared_memory, mem_dat_st
    );
endinterface

// File: rtl/gpu_core_param.sv
// Parametrised shader core: loads a program, runs it as a multi-cycle FSM, talks to SM by req/valid.
// Optional GPU_CORE_PERF_EN adds perf_retired, a saturating retired-instruction count per task.
module gpu_core_param #(
    parameter int DATA_W     = 8,
    parameter int IMEM_DEPTH = 16,
    parameter int NUM_REGS   = 16,
    parameter int ADDR_W     = 12,
    parameter int CORE_ID    = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    gpu_core_param_if.master bus,
    output logic [3:0]       core_id
`ifdef GPU_CORE_PERF_EN
    ,
    output logic [15:0]      perf_retired
`endif
);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_MUL  = 4'h3;
    localparam logic [3:0] OP_DIV  = 4'h4;
    localparam logic [3:0] OP_GE   = 4'h5;
    localparam logic [3:0] OP_SHR  = 4'h6;
    localparam logic [3:0] OP_SHL  = 4'h7;
    localparam logic [3:0] OP_AND  = 4'h8;
    localparam logic [3:0] OP_OR   = 4'h9;
    localparam logic [3:0] OP_XOR  = 4'hA;
    localparam logic [3:0] OP_LD   = 4'hB;
    localparam logic [3:0] OP_LI   = 4'hC;
    localparam logic [3:0] OP_ST   = 4'hD;
    localparam logic [3:0] OP_BNZ  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [3:0] LAST_IDX = 4'(IMEM_DEPTH - 1);

    typedef enum logic [2:0] {
        S_LOAD,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_MEM_WAIT,
        S_WB
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [15:0]       imem_mem [IMEM_DEPTH];
    logic [15:0]       imem_rd_reg;
    logic [DATA_W-1:0] rf_reg [NUM_REGS];

    logic [3:0]        ptr_reg;
    logic [3:0]        pc_reg;
    logic [15:0]       ir_reg;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic [DATA_W-1:0] d_reg;
    logic [DATA_W-1:0] result_reg;
    logic [DATA_W-1:0] alu_next;
    logic              ready_reg;
    logic              mem_req_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] dat_st_reg;

    logic [3:0]          op;
    logic [3:0]          rd;
    logic                load_accept;
    logic                load_last;
    logic                is_mem_op;
    logic                branch_taken;
    logic                task_end;
    logic                mem_done;
    logic                writes_rf;
    logic [2*DATA_W-1:0] mem_addr_full;

    assign op            = ir_reg[15:12];
    assign rd            = ir_reg[3:0];
    assign load_accept   = (state_reg == S_LOAD) && bus.val_ins;
    assign load_last     = (ptr_reg == LAST_IDX);
    assign is_mem_op     = (op == OP_LD) || (op == OP_ST);
    assign branch_taken  = (op == OP_BNZ) && (a_reg != '0);
    assign task_end      = (op == OP_HALT) || (!branch_taken && (pc_reg == LAST_IDX));
    assign mem_done      = (state_reg == S_MEM_WAIT) && bus.val_data && mem_req_reg;
    assign writes_rf     = (op >= OP_ADD) && (op <= OP_LI);
    assign mem_addr_full = {b_reg, a_reg};

    assign bus.rtr                = (state_reg == S_LOAD);
    assign bus.ready              = ready_reg;
    assign bus.mem_req            = mem_req_reg;
    assign bus.mem_we             = mem_we_reg;
    assign bus.addr_shared_memory = addr_reg;
    assign bus.mem_dat_st         = dat_st_reg;
    assign core_id                = 4'(CORE_ID);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_LOAD;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_LOAD:     if (load_accept && load_last) state_next = S_FETCH;
            S_FETCH:    state_next = S_DECODE;
            S_DECODE:   state_next = S_EXEC;
            S_EXEC:     state_next = S_MEM;
            S_MEM:      state_next = is_mem_op ? S_MEM_WAIT : S_WB;
            S_MEM_WAIT: if (mem_done) state_next = S_WB;
            S_WB:       state_next = task_end ? S_LOAD : S_FETCH;
            default:    state_next = S_LOAD;
        endcase
    end

    // LI shares bit 3 between rd and the mode select, so immediates land in r8..r15
    // and the core-id form in r0..r7.
    always_comb begin
        alu_next = '0;
        case (op)
            OP_ADD: alu_next = a_reg + b_reg;
            OP_SUB: alu_next = a_reg - b_reg;
            OP_MUL: alu_next = a_reg * b_reg;
            OP_DIV: alu_next = (b_reg == '0) ? '1 : (a_reg / b_reg);
            OP_GE:  alu_next = {{(DATA_W-1){1'b0}}, (a_reg >= b_reg)};
            OP_SHR: alu_next = a_reg >> b_reg[3:0];
            OP_SHL: alu_next = a_reg << b_reg[3:0];
            OP_AND: alu_next = a_reg & b_reg;
            OP_OR:  alu_next = a_reg | b_reg;
            OP_XOR: alu_next = a_reg ^ b_reg;
            OP_LI:  alu_next = ir_reg[3] ? DATA_W'(ir_reg[11:4]) : DATA_W'(CORE_ID);
            default: alu_next = '0;
        endcase
    end

    // Program store: plain array with registered read so it maps to block RAM.
    always_ff @(posedge clk) begin
        if (load_accept) begin
            imem_mem[ptr_reg] <= bus.instruction;
        end
        imem_rd_reg <= imem_mem[pc_reg];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_reg     <= '0;
            pc_reg      <= '0;
            ir_reg      <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            d_reg       <= '0;
            result_reg  <= '0;
            ready_reg   <= 1'b0;
            mem_req_reg <= 1'b0;
            mem_we_reg  <= 1'b0;
            addr_reg    <= '0;
            dat_st_reg  <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                S_LOAD: begin
                    if (load_accept) begin
                        if (ptr_reg == 4'd0) ready_reg <= 1'b0;
                        if (load_last) begin
                            ptr_reg <= '0;
                            pc_reg  <= '0;
                        end else begin
                            ptr_reg <= ptr_reg + 4'd1;
                        end
                    end
                end
                S_DECODE: begin
                    ir_reg <= imem_rd_reg;
                    a_reg  <= rf_reg[imem_rd_reg[11:8]];
                    b_reg  <= rf_reg[imem_rd_reg[7:4]];
                    d_reg  <= rf_reg[imem_rd_reg[3:0]];
                end
                S_EXEC: begin
                    result_reg <= alu_next;
                end
                S_MEM: begin
                    if (is_mem_op) begin
                        mem_req_reg <= 1'b1;
                        mem_we_reg  <= (op == OP_ST);
                        addr_reg    <= mem_addr_full[ADDR_W-1:0];
                        dat_st_reg  <= d_reg;
                    end
                end
                S_MEM_WAIT: begin
                    if (mem_done) begin
                        mem_req_reg <= 1'b0;
                        mem_we_reg  <= 1'b0;
                        if (op == OP_LD) result_reg <= bus.mem_dat;
                    end
                end
                S_WB: begin
                    if (writes_rf) rf_reg[rd] <= result_reg;
                    pc_reg <= branch_taken ? ir_reg[7:4] : (pc_reg + 4'd1);
                    if (task_end) begin
                        ready_reg <= 1'b1;
                        ptr_reg   <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef GPU_CORE_PERF_EN
    logic [15:0] perf_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_reg <= '0;
        end else if (load_accept && (ptr_reg == 4'd0)) begin
            perf_reg <= '0;
        end else if ((state_reg == S_WB) && (perf_reg != 16'hFFFF)) begin
            perf_reg <= perf_reg + 16'd1;
        end
    end

    assign perf_retired = perf_reg;
`endif

endmodule

// File: tb/tb_gpu_core_param.sv
// Directed bench for gpu_core_param: program loads, ALU results observed through stores,
// SM handshake, looping branch timing and mid-transaction reset.
module tb_gpu_core_param;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 12;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] core_id;

    gpu_core_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    gpu_core_param #(
        .DATA_W(DATA_W), .IMEM_DEPTH(16), .NUM_REGS(16), .ADDR_W(ADDR_W), .CORE_ID(1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus),
        .core_id(core_id)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    logic [15:0] prog [16];

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) prog[i] = 16'h0000;
    endtask

    task automatic load_program(output logic rdy_after_first);
        rdy_after_first = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.val_ins = 1'b1;
            bus.instruction = prog[i];
            step();
            if (i == 0) rdy_after_first = bus.ready;
        end
        bus.val_ins = 1'b0;
        bus.instruction = 16'h0000;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (bus.mem_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic complete_mem(input int hold, input logic [7:0] rdata);
        for (int i = 0; i < hold; i++) step();
        bus.val_data = 1'b1;
        bus.mem_dat = rdata;
        step();
        bus.val_data = 1'b0;
        bus.mem_dat = 8'h5A;
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (bus.ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.rtr !== 1'b1) $display("FAIL reset_rtr: got %b want 1", bus.rtr); else passed++;
        checks++; if (bus.ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", bus.ready); else passed++;
        checks++; if (bus.mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); else passed++;
        checks++; if (bus.mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); else passed++;
        checks++; if (bus.addr_shared_memory !== 12'h000) $display("FAIL reset_addr: got %h want 000", bus.addr_shared_memory); else passed++;
        checks++; if (bus.mem_dat_st !== 8'h00) $display("FAIL reset_dat_st: got %h want 00", bus.mem_dat_st); else passed++;
        checks++; if (core_id !== 4'd1) $display("FAIL core_id: got %0d want 1", core_id); else passed++;
        reset_n = 1'b1;
        step();
        $display("reset: done");
    endtask

    // LI r9=5, LI r10=3, ADD r3=r9+r10, HALT: four instructions, ready after 20 edges.
    task automatic test_load_li_add();
        clear_prog();
        prog[0] = 16'hC059; prog[1] = 16'hC03A; prog[2] = 16'h19A3; prog[3] = 16'hF000;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) begin
                checks++; if (bus.rtr !== 1'b1) $display("FAIL load_rtr_before_last: got %b want 1", bus.rtr); else passed++;
            end
            bus.val_ins = 1'b1;
            bus.instruction = prog[i];
            step();
        end
        checks++; if (bus.rtr !== 1'b0) $display("FAIL load_rtr_after_last: got %b want 0", bus.rtr); else passed++;
        // HALT words offered while executing must be ignored
        bus.instruction = 16'hF000;
        for (int i = 0; i < 19; i++) begin
            bus.val_ins = (i < 12) ? 1'b1 : 1'b0;
            step();
        end
        bus.instruction = 16'h0000;
        checks++; if (bus.ready !== 1'b0) $display("FAIL li_add_ready_early: got %b want 0 at cycle 19", bus.ready); else passed++;
        step();
        checks++; if (bus.ready !== 1'b1) $display("FAIL li_add_ready_time: got %b want 1 at cycle 20", bus.ready); else passed++;
        checks++; if (bus.rtr !== 1'b1) $display("FAIL li_add_rtr_end: got %b want 1", bus.rtr); else passed++;
        $display("load_li_add: program of 4 instrs finished");
    endtask

    // DIV by zero, MUL overflow, SUB wrap, GE, LI-id, SHL; results stored to 0x001.
    task automatic test_alu();
        logic rdy;
        bit ok;
        logic [7:0] exp_st [6];
        exp_st = '{8'h08, 8'hFF, 8'h00, 8'hF7, 8'h01, 8'h0E};
        clear_prog();
        prog[0]  = 16'hC079; prog[1]  = 16'hC00A; prog[2]  = 16'h49A4; prog[3]  = 16'hC10B;
        prog[4]  = 16'h3BB5; prog[5]  = 16'h29B6; prog[6]  = 16'h5B97; prog[7]  = 16'hC000;
        prog[8]  = 16'hD0A3; prog[9]  = 16'hD0A4; prog[10] = 16'hD0A5; prog[11] = 16'hD0A6;
        prog[12] = 16'hD0A7; prog[13] = 16'h790C; prog[14] = 16'hD0AC; prog[15] = 16'hF000;
        checks++; if (bus.ready !== 1'b1) $display("FAIL alu_ready_before_load: got %b want 1", bus.ready); else passed++;
        load_program(rdy);
        checks++; if (rdy !== 1'b0) $display("FAIL alu_ready_cleared_first_word: got %b want 0", rdy); else passed++;
        for (int s = 0; s < 6; s++) begin
            wait_req(ok);
            checks++; if (!ok) $display("FAIL alu_st%0d_req: got timeout want mem_req", s); else passed++;
            checks++; if (bus.mem_we !== 1'b1) $display("FAIL alu_st%0d_we: got %b want 1", s, bus.mem_we); else passed++;
            checks++; if (bus.addr_shared_memory !== 12'h001) $display("FAIL alu_st%0d_addr: got %h want 001", s, bus.addr_shared_memory); else passed++;
            checks++; if (bus.mem_dat_st !== exp_st[s]) $display("FAIL alu_st%0d_data: got %h want %h", s, bus.mem_dat_st, exp_st[s]); else passed++;
            $display("alu: store %0d data %h", s, bus.mem_dat_st);
            complete_mem(0, 8'h00);
        end
        wait_ready(ok);
        checks++; if (!ok) $display("FAIL alu_ready_end: got timeout want ready=1"); else passed++;
    endtask

    // ST 0xAB to 0x123 held four cycles, LD it back into r14, ST r14 to confirm.
    task automatic test_mem_handshake();
        logic rdy;
        bit ok;
        clear_prog();
        prog[0] = 16'hC239; prog[1] = 16'hC01A; prog[2] = 16'hCABD; prog[3] = 16'hD9AD;
        prog[4] = 16'hB9AE; prog[5] = 16'hD9AE; prog[6] = 16'hF000;
        load_program(rdy);
        wait_req(ok);
        checks++; if (!ok) $display("FAIL st_req: got timeout want mem_req"); else passed++;
        checks++; if (bus.mem_we !== 1'b1) $display("FAIL st_we: got %b want 1", bus.mem_we); else passed++;
        checks++; if (bus.addr_shared_memory !== 12'h123) $display("FAIL st_addr: got %h want 123", bus.addr_shared_memory); else passed++;
        checks++; if (bus.mem_dat_st !== 8'hAB) $display("FAIL st_data: got %h want AB", bus.mem_dat_st); else passed++;
        for (int k = 1; k < 4; k++) begin
            step();
            checks++;
            if (bus.mem_req !== 1'b1 || bus.addr_shared_memory !== 12'h123 || bus.mem_dat_st !== 8'hAB)
                $display("FAIL st_hold%0d: got req=%b addr=%h data=%h want req=1 addr=123 data=AB",
                         k, bus.mem_req, bus.addr_shared_memory, bus.mem_dat_st);
            else passed++;
        end
        complete_mem(0, 8'h00);
        checks++; if (bus.mem_req !== 1'b0) $display("FAIL st_req_drop: got %b want 0", bus.mem_req); else passed++;
        $display("mem: store to 123 completed after 4 req cycles");
        wait_req(ok);
        checks++; if (!ok) $display("FAIL ld_req: got timeout want mem_req"); else passed++;
        checks++; if (bus.mem_we !== 1'b0) $display("FAIL ld_we: got %b want 0", bus.mem_we); else passed++;
        checks++; if (bus.addr_shared_memory !== 12'h123) $display("FAIL ld_addr: got %h want 123", bus.addr_shared_memory); else passed++;
        complete_mem(1, 8'hAB);
        checks++; if (bus.mem_req !== 1'b0) $display("FAIL ld_req_drop: got %b want 0", bus.mem_req); else passed++;
        $display("mem: load from 123 returned AB");
        wait_req(ok);
        checks++; if (!ok) $display("FAIL ld_check_req: got timeout want mem_req"); else passed++;
        checks++; if (bus.mem_dat_st !== 8'hAB) $display("FAIL ld_value: got %h want AB", bus.mem_dat_st); else passed++;
        complete_mem(0, 8'h00);
        wait_ready(ok);
        checks++; if (!ok) $display("FAIL mem_ready_end: got timeout want ready=1"); else passed++;
    endtask

    // Countdown r9=3 with BNZ at PC 15 back to PC 3: 42 instrs, 3 one-wait stores -> 213 cycles.
    task automatic test_branch_loop();
        logic rdy;
        bit ok;
        int start;
        logic [7:0] exp_cnt [3];
        exp_cnt = '{8'h02, 8'h01, 8'h00};
        clear_prog();
        prog[0] = 16'hC039; prog[1] = 16'hC01A; prog[2] = 16'hC00B; prog[3] = 16'h29A9;
        prog[4] = 16'hDBB9; prog[15] = 16'hE930;
        load_program(rdy);
        start = cyc;
        for (int s = 0; s < 3; s++) begin
            wait_req(ok);
            checks++;
            if (!ok || bus.mem_dat_st !== exp_cnt[s] || bus.addr_shared_memory !== 12'h000)
                $display("FAIL loop_st%0d: got ok=%0d addr=%h data=%h want addr=000 data=%h",
                         s, ok, bus.addr_shared_memory, bus.mem_dat_st, exp_cnt[s]);
            else passed++;
            $display("branch: iteration %0d count %h", s, bus.mem_dat_st);
            complete_mem(0, 8'h00);
        end
        wait_ready(ok);
        checks++; if (!ok || (cyc - start) != 213) $display("FAIL loop_cycles: got %0d want 213", cyc - start); else passed++;
        checks++; if (bus.rtr !== 1'b1) $display("FAIL loop_rtr_end: got %b want 1", bus.rtr); else passed++;
    endtask

    // Reset while a store waits: request drops at once, RF clears, next program runs.
    task automatic test_reset_mid_task();
        logic rdy;
        bit ok;
        clear_prog();
        prog[0] = 16'hD0A3; prog[1] = 16'hF000;
        load_program(rdy);
        wait_req(ok);
        checks++; if (!ok) $display("FAIL rst_mid_req: got timeout want mem_req"); else passed++;
        step();
        step();
        #2 reset_n = 1'b0;
        #1;
        checks++; if (bus.mem_req !== 1'b0) $display("FAIL rst_mid_mem_req: got %b want 0", bus.mem_req); else passed++;
        checks++; if (bus.rtr !== 1'b1) $display("FAIL rst_mid_rtr: got %b want 1", bus.rtr); else passed++;
        checks++; if (bus.mem_we !== 1'b0) $display("FAIL rst_mid_mem_we: got %b want 0", bus.mem_we); else passed++;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step();
        clear_prog();
        prog[0] = 16'hDBB3; prog[1] = 16'hDBBD; prog[2] = 16'hF000;
        load_program(rdy);
        for (int s = 0; s < 2; s++) begin
            wait_req(ok);
            checks++;
            if (!ok || bus.mem_dat_st !== 8'h00 || bus.addr_shared_memory !== 12'h000)
                $display("FAIL rst_rf_zero%0d: got ok=%0d addr=%h data=%h want addr=000 data=00",
                         s, ok, bus.addr_shared_memory, bus.mem_dat_st);
            else passed++;
            complete_mem(0, 8'h00);
        end
        wait_ready(ok);
        checks++; if (!ok) $display("FAIL rst_new_prog_ready: got timeout want ready=1"); else passed++;
        $display("reset_mid_task: new program completed");
    endtask

    initial begin
        bus.val_ins = 1'b0;
        bus.instruction = 16'h0000;
        bus.mem_dat = 8'h00;
        bus.val_data = 1'b0;
        test_reset();
        test_load_li_add();
        test_alu();
        test_mem_handshake();
        test_branch_loop();
        test_reset_mid_task();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
